// File: rtl/led_addr_seq.sv
// -----------------------------------------------------------------------------
// led_addr_seq
//   Address sequencer feeding the LED pattern ROM stage. A prescaler divides
//   the system clock down to a visible step rate; each prescaler wrap advances
//   the ROM address by ADDR_STEP (modulo 2^ADDR_W). A hold request/acknowledge
//   handshake lets the PR controller freeze the pattern path and disable the
//   ROM before the reconfigurable module is swapped.
//
//   Parameters:
//     TICK_DIV  : clk cycles per address step (2 .. 2^32-1)
//     ADDR_W    : ROM address width
//     ADDR_STEP : address increment per step
//
//   Ports:
//     clk      : system clock (only clock)
//     en       : asynchronous active-low reset
//     run      : 1 = sequence runs, 0 = return to idle
//     hold_req : freeze/decouple request from the PR controller
//     hold_ack : 1 = outputs frozen, ROM disabled, safe to reconfigure
//     addr     : registered ROM address
//     ram_en   : registered ROM enable (0 forces ROM output to SRVAL)
//     tick     : one-cycle pulse when addr takes a new stepped value
//     busy     : 1 whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module led_addr_seq #(
  parameter int unsigned TICK_DIV  = 32'd50000000,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned ADDR_STEP = 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic              run,
  input  logic              hold_req,
  output logic              hold_ack,
  output logic [ADDR_W-1:0] addr,
  output logic              ram_en,
  output logic              tick,
  output logic              busy
);

  localparam int unsigned       PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(ADDR_STEP);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic              drain_q, drain_d;
  logic [ADDR_W-1:0] addr_d;
  logic              tick_d;
  logic              term;

  assign term = (state_q == RUN) && (pre_q == PRE_LAST);

  // Next-state and next-output logic. All outputs are registered from the
  // values computed here, so no input reaches an output combinationally.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    drain_d = drain_q;
    addr_d  = addr;
    tick_d  = 1'b0;

    case (state_q)
      IDLE: begin
        pre_d   = '0;
        addr_d  = '0;
        drain_d = 1'b0;
        if (hold_req)  state_d = HOLD;
        else if (run)  state_d = RUN;
      end

      RUN: begin
        // The prescaler keeps counting in the cycle a transition is taken,
        // so a terminal count there still steps addr and pulses tick.
        if (term) begin
          pre_d  = '0;
          addr_d = addr + STEP;
          tick_d = 1'b1;
        end else begin
          pre_d  = pre_q + PRE_W'(1);
        end

        if (hold_req) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end else if (!run) begin
          state_d = IDLE;
          pre_d   = '0;
          // A coinciding step wins; IDLE clears addr one cycle later.
          if (!term) addr_d = '0;
        end
      end

      DRAIN: begin
        // Two cycles with the ROM still enabled so its 1-cycle read
        // latency settles on the last pattern before it is disabled.
        drain_d = 1'b1;
        if (drain_q) state_d = HOLD;
      end

      HOLD: begin
        if (!hold_req) begin
          if (run) begin
            state_d = RUN;
          end else begin
            state_d = IDLE;
            addr_d  = '0;
            pre_d   = '0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge en) begin
    if (!en) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      drain_q  <= 1'b0;
      addr     <= '0;
      tick     <= 1'b0;
      ram_en   <= 1'b0;
      hold_ack <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      drain_q  <= drain_d;
      addr     <= addr_d;
      tick     <= tick_d;
      ram_en   <= (state_d == RUN) || (state_d == DRAIN);
      hold_ack <= (state_d == HOLD);
      busy     <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_led_addr_seq.sv
// -----------------------------------------------------------------------------
// tb_led_addr_seq
//   Self-checking bench for led_addr_seq with TICK_DIV=4, ADDR_W=12,
//   ADDR_STEP=1. A cycle-level reference model tracks mode, RUN-cycle phase
//   and address; a compare process checks every output on every falling edge.
//   Directed literal checks pin the model to hand-computed cycle numbers,
//   followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_led_addr_seq;

  localparam int unsigned TD     = 4;
  localparam int unsigned AW     = 12;
  localparam int unsigned STEP_V = 1;

  logic          clk = 1'b0;
  logic          en;
  logic          run;
  logic          hold_req;
  logic          hold_ack;
  logic [AW-1:0] addr;
  logic          ram_en;
  logic          tick;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  led_addr_seq #(
    .TICK_DIV (TD),
    .ADDR_W   (AW),
    .ADDR_STEP(STEP_V)
  ) dut (
    .clk     (clk),
    .en      (en),
    .run     (run),
    .hold_req(hold_req),
    .hold_ack(hold_ack),
    .addr    (addr),
    .ram_en  (ram_en),
    .tick    (tick),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef enum logic [1:0] {M_IDLE, M_RUN, M_DRAIN, M_HOLD} mmode_t;

  typedef struct packed {
    mmode_t        mode;
    logic [1:0]    drain_left;
    logic [31:0]   phase;      // RUN cycles since the last step
    logic [AW-1:0] addr;
    logic          tick;
  } model_t;

  model_t m;

  function automatic model_t model_step(model_t cur, logic r, logic h);
    model_t n = cur;
    n.tick = 1'b0;
    case (cur.mode)
      M_IDLE: begin
        n.addr  = '0;
        n.phase = '0;
        if (h)      n.mode = M_HOLD;
        else if (r) n.mode = M_RUN;
      end
      M_RUN: begin
        n.phase = cur.phase + 32'd1;
        if (n.phase == 32'(TD)) begin
          n.phase = '0;
          n.addr  = cur.addr + AW'(STEP_V);
          n.tick  = 1'b1;
        end
        if (h) begin
          n.mode       = M_DRAIN;
          n.drain_left = 2'd2;
        end else if (!r) begin
          n.mode  = M_IDLE;
          n.phase = '0;
          if (!n.tick) n.addr = '0;
        end
      end
      M_DRAIN: begin
        n.drain_left = cur.drain_left - 2'd1;
        if (n.drain_left == 2'd0) n.mode = M_HOLD;
      end
      M_HOLD: begin
        if (!h) begin
          if (r) begin
            n.mode = M_RUN;
          end else begin
            n.mode  = M_IDLE;
            n.addr  = '0;
            n.phase = '0;
          end
        end
      end
      default: n.mode = M_IDLE;
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge en) begin
    if (!en) m <= '0;
    else     m <= model_step(m, run, hold_req);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_addr",     32'(addr),     32'(m.addr));
      check("m_tick",     32'(tick),     32'(m.tick));
      check("m_ram_en",   32'(ram_en),   32'((m.mode == M_RUN) || (m.mode == M_DRAIN)));
      check("m_hold_ack", 32'(hold_ack), 32'(m.mode == M_HOLD));
      check("m_busy",     32'(busy),     32'(m.mode != M_IDLE));
    end
  end

  task automatic tk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    en = 1'b0; run = 1'b0; hold_req = 1'b0;
    tk(3);
    chk_en = 1'b1;
    check("rst_addr",     32'(addr),     32'd0);
    check("rst_ram_en",   32'(ram_en),   32'd0);
    check("rst_hold_ack", 32'(hold_ack), 32'd0);
    check("rst_tick",     32'(tick),     32'd0);
    check("rst_busy",     32'(busy),     32'd0);

    // cycle 0: release reset with run=1
    en = 1'b1; run = 1'b1;
    for (int c = 1; c <= 16387; c++) begin
      @(negedge clk);
      if (c <= 13 || c >= 16375) begin
        check("seq_tick",   32'(tick),   (c >= 5 && (c - 5) % 4 == 0) ? 32'd1 : 32'd0);
        check("seq_addr",   32'(addr),   32'(((c - 1) / 4) % 4096));
        check("seq_ram_en", 32'(ram_en), 32'd1);
      end
    end
    // prescaler is 2 in cycle 16387
    hold_req = 1'b1;
    tk(1);
    check("drain1_ram_en", 32'(ram_en),   32'd1);
    check("drain1_ack",    32'(hold_ack), 32'd0);
    check("drain1_tick",   32'(tick),     32'd0);
    tk(1);
    check("drain2_ram_en", 32'(ram_en),   32'd1);
    check("drain2_ack",    32'(hold_ack), 32'd0);
    tk(1);
    check("hold_ack",    32'(hold_ack), 32'd1);
    check("hold_ram_en", 32'(ram_en),   32'd0);
    check("hold_addr",   32'(addr),     32'd0);
    check("hold_busy",   32'(busy),     32'd1);
    run = 1'b0;
    tk(2);
    check("hold_run_ign", 32'(hold_ack), 32'd1);
    run = 1'b1;
    tk(1);
    hold_req = 1'b0;
    tk(1);
    check("resume_ram_en", 32'(ram_en),   32'd1);
    check("resume_ack",    32'(hold_ack), 32'd0);
    check("resume_tick",   32'(tick),     32'd0);
    tk(1);
    check("resume_tick1", 32'(tick), 32'd1);
    check("resume_addr1", 32'(addr), 32'd1);

    // run=0 and hold_req=1 together
    run = 1'b0; hold_req = 1'b1;
    tk(1);
    check("rh_d1_ram_en", 32'(ram_en), 32'd1);
    check("rh_d1_addr",   32'(addr),   32'd1);
    tk(1);
    check("rh_d2_busy", 32'(busy), 32'd1);
    tk(1);
    check("rh_hold_ack", 32'(hold_ack), 32'd1);
    check("rh_hold_addr", 32'(addr),    32'd1);
    hold_req = 1'b0;
    tk(1);
    check("rh_idle_busy", 32'(busy),     32'd0);
    check("rh_idle_addr", 32'(addr),     32'd0);
    check("rh_idle_ack",  32'(hold_ack), 32'd0);

    // hold straight from IDLE
    hold_req = 1'b1;
    tk(1);
    check("ih_ack",    32'(hold_ack), 32'd1);
    check("ih_ram_en", 32'(ram_en),   32'd0);

    // walk to addr=7, then hold and reset while held
    hold_req = 1'b0; run = 1'b1;
    tk(1);
    check("ih_run_ram_en", 32'(ram_en), 32'd1);
    tk(28);
    check("a7_tick", 32'(tick), 32'd1);
    check("a7_addr", 32'(addr), 32'd7);
    hold_req = 1'b1;
    tk(3);
    check("a7_hold_ack",  32'(hold_ack), 32'd1);
    check("a7_hold_addr", 32'(addr),     32'd7);
    #2 en = 1'b0;
    #1;
    check("arst_ack",    32'(hold_ack), 32'd0);
    check("arst_addr",   32'(addr),     32'd0);
    check("arst_ram_en", 32'(ram_en),   32'd0);
    check("arst_tick",   32'(tick),     32'd0);
    check("arst_busy",   32'(busy),     32'd0);
    @(negedge clk);
    en = 1'b1; run = 1'b0; hold_req = 1'b0;
    tk(1);
    check("post_rst_busy",   32'(busy),   32'd0);
    check("post_rst_ram_en", 32'(ram_en), 32'd0);

    // randomized phase
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) hold_req = ~hold_req;
      if ($urandom_range(9) == 0) run = ~run;
      if ($urandom_range(299) == 0) begin
        #2 en = 1'b0;
        @(negedge clk);
        en = 1'b1;
      end
    end

    tk(1);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
